// File: rtl/bt_pkg.sv
// Shared constants, FSM encoding and frame-byte helpers for the Bluetooth
// game-state transmitter.
package bt_pkg;

    localparam logic [7:0] BT_HDR       = 8'hA5;
    localparam int         BT_FRAME_LEN = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] bt_checksum(input logic [9:0] px, input logic [9:0] px2);
        return {6'b0, px[9:8]} ^ px[7:0] ^ {6'b0, px2[9:8]} ^ px2[7:0];
    endfunction

    function automatic logic [7:0] bt_frame_byte(input logic [2:0] idx,
                                                 input logic [9:0] px,
                                                 input logic [9:0] px2,
                                                 input logic [7:0] chk);
        logic [7:0] b;
        case (idx)
            3'd0:    b = BT_HDR;
            3'd1:    b = {6'b0, px[9:8]};
            3'd2:    b = px[7:0];
            3'd3:    b = {6'b0, px2[9:8]};
            3'd4:    b = px2[7:0];
            3'd5:    b = chk;
            default: b = BT_HDR;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A byte offered with valid in the cycle ready is high
// starts on the very next cycle, so consecutive bytes have no gap.
module uart_tx_byte
    import bt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int             TW     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  T_ONE  = TW'(1);

    tx_state_e      state_r, state_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic [2:0]     bit_idx_r, bit_idx_s;
    logic [7:0]     shreg_r, shreg_s;
    logic           tx_r, tx_s;
    logic           ready_r, ready_s;
    logic           bit_end_s;

    // Next-state and next-output logic for the serializer FSM.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shreg_s   = shreg_r;
        tx_s      = tx_r;
        bit_end_s = (timer_r == T_LAST);
        case (state_r)
            ST_IDLE: begin
                timer_s = '0;
                if (valid) begin
                    state_s = ST_START;
                    shreg_s = data;
                    tx_s    = 1'b0;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s   = ST_DATA;
                    timer_s   = '0;
                    bit_idx_s = 3'd0;
                    tx_s      = shreg_r[0];
                end else begin
                    timer_s   = timer_r + T_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    timer_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shreg_s   = {1'b0, shreg_r[7:1]};
                        tx_s      = shreg_r[1];
                    end
                end else begin
                    timer_s = timer_r + T_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    timer_s = '0;
                    if (valid) begin
                        state_s = ST_START;
                        shreg_s = data;
                        tx_s    = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    timer_s = timer_r + T_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = '0;
                tx_s    = 1'b1;
            end
        endcase
        // ready is registered one cycle early so it lands exactly on the last stop-bit cycle
        ready_s = (state_s == ST_STOP) && (timer_s == T_LAST);
    end

    // Serializer state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'd0;
            tx_r      <= 1'b1;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shreg_r   <= shreg_s;
            tx_r      <= tx_s;
            ready_r   <= ready_s;
        end
    end

    assign ready = ready_r;
    assign tx    = tx_r;

endmodule

// File: rtl/bt_state_tx.sv
// Streams {header, x, x2, checksum} frames over UART to the Bluetooth module;
// snapshots positions on accept and sequences the six bytes back to back.
module bt_state_tx
    import bt_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_req,
    input  logic [9:0] x,
    input  logic [9:0] x2,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [2:0] LAST_BYTE    = 3'(BT_FRAME_LEN - 1);

    if (CLKS_PER_BIT < 2) begin : g_cfg_err
        $error("bt_state_tx: CLK_HZ/BAUD must be at least 2");
    end

    logic       busy_r;
    logic       frame_done_r;
    logic       overrun_r;
    logic [2:0] byte_idx_r;
    logic [9:0] x_r;
    logic [9:0] x2_r;
    logic [7:0] chk_r;
    logic       accept_s;
    logic       valid_s;
    logic [7:0] data_s;
    logic       ready_s;

    assign accept_s = send_req && !busy_r;

    // Byte offered to the serializer: header on accept, then the snapshot bytes.
    always_comb begin
        valid_s = 1'b0;
        data_s  = 8'd0;
        if (!busy_r) begin
            valid_s = accept_s;
            data_s  = BT_HDR;
        end else begin
            valid_s = ready_s && (byte_idx_r < LAST_BYTE);
            data_s  = bt_frame_byte(byte_idx_r + 3'd1, x_r, x2_r, chk_r);
        end
    end

    // Frame sequencing, snapshot and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            byte_idx_r   <= 3'd0;
            x_r          <= 10'd0;
            x2_r         <= 10'd0;
            chk_r        <= 8'd0;
        end else begin
            frame_done_r <= 1'b0;
            if (accept_s) begin
                busy_r     <= 1'b1;
                byte_idx_r <= 3'd0;
                x_r        <= x;
                x2_r       <= x2;
                chk_r      <= bt_checksum(x, x2);
            end else if (busy_r && ready_s) begin
                if (byte_idx_r == LAST_BYTE) begin
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b1;
                    byte_idx_r   <= 3'd0;
                end else begin
                    byte_idx_r   <= byte_idx_r + 3'd1;
                end
            end
            if (send_req && busy_r) begin
                overrun_r <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data_s),
        .valid (valid_s),
        .ready (ready_s),
        .tx    (tx)
    );

    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_bt_state_tx.sv
// Scoreboard bench for bt_state_tx at 10 clocks per bit: a line decoder pops
// expected bytes queued when each frame is requested.
module tb_bt_state_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send_req = 1'b0;
    logic [9:0] x = 10'd0;
    logic [9:0] x2 = 10'd0;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    bt_state_tx #(
        .CLK_HZ (1000),
        .BAUD   (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .send_req   (send_req),
        .x          (x),
        .x2         (x2),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line decoder: samples mid-bit on the falling edge and pops the scoreboard.
    initial begin
        int         mon_cnt;
        logic       mon_active;
        logic [7:0] mon_byte;
        mon_cnt    = 0;
        mon_active = 1'b0;
        mon_byte   = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                mon_cnt    = 0;
            end else if (!mon_active) begin
                if (tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == 5) begin
                    check("start_bit", tx, 1'b0);
                end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
                    mon_byte[mon_cnt / 10 - 1] = tx;
                end else if (mon_cnt == 95) begin
                    check("stop_bit", tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_underflow: got byte %0h expected none", mon_byte);
                    end else begin
                        check("line_byte", mon_byte, exp_q.pop_front());
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic push_frame(input logic [9:0] a, input logic [9:0] b);
        logic [7:0] b1, b2, b3, b4;
        b1 = {6'b0, a[9:8]};
        b2 = a[7:0];
        b3 = {6'b0, b[9:8]};
        b4 = b[7:0];
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
        exp_q.push_back(b1 ^ b2 ^ b3 ^ b4);
    endtask

    task automatic idle(input int n);
        int lows;
        lows = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check("idle_tx_low_cycles", lows, 0);
    endtask

    // mode: 0 plain, 1 change x after accept, 2 request mid-frame, 4 reset mid-frame
    task automatic run_frame(input logic [9:0] a, input logic [9:0] b, input int mode);
        int c, it, fd;
        send_req = 1'b1;
        x        = a;
        x2       = b;
        push_frame(a, b);
        @(posedge clk);
        #1;
        send_req = 1'b0;
        check("accept_busy", busy, 1'b1);
        check("accept_start_bit", tx, 1'b0);
        c  = 1;
        it = 0;
        fd = 0;
        while (busy && it < 700) begin
            if (mode == 1 && c == 1) x = 10'd0;
            if (mode == 2 && c == 200) send_req = 1'b1;
            if (mode == 4 && c == 250) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                check("midreset_tx", tx, 1'b1);
                check("midreset_busy", busy, 1'b0);
                check("midreset_overrun", overrun, 1'b0);
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end
            @(posedge clk);
            #1;
            send_req = 1'b0;
            it++;
            if (busy) c++;
            if (frame_done) fd++;
        end
        check("busy_cycles", c, 600);
        check("frame_done_at_end", frame_done, 1'b1);
        check("frame_done_count", fd, 1);
        check("sb_drained", exp_q.size(), 0);
        if (mode == 2) check("overrun_set", overrun, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        idle(100);

        run_frame(10'h155, 10'h2AA, 0);
        idle(20);
        check("overrun_clear_t2", overrun, 1'b0);

        run_frame(10'h155, 10'h2AA, 1);
        idle(20);

        run_frame(10'h3FF, 10'h000, 0);
        run_frame(10'h123, 10'h0F0, 0);
        check("overrun_clear_b2b", overrun, 1'b0);
        idle(20);

        run_frame(10'h2AA, 10'h155, 2);
        idle(20);
        check("overrun_sticky", overrun, 1'b1);

        run_frame(10'h155, 10'h2AA, 4);
        check("overrun_after_reset", overrun, 1'b0);
        idle(10);
        run_frame(10'h0C3, 10'h301, 0);
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
